// File: rtl/mod_n_counter_if.sv
// Control and status bundle for one mod_n_counter stage.
// The master side drives the count controls; the slave side is the counter itself.
interface mod_n_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             co;
  logic             wrapped;
  logic             load_err;

  modport master (
    output en, up_dn, load, load_val, clr_flag,
    input  count, tc, co, wrapped, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val, clr_flag,
    output count, tc, co, wrapped, load_err
  );
endinterface

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with parallel load, wrap or saturate
// at the terminal value, registered terminal count and combinational cascade carry.
module mod_n_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 6,
  parameter int SATURATE = 0
) (
  input logic             clk,
  input logic             rst,
  mod_n_counter_if.slave  bus
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] term;
  logic             tc_p0;
  logic             tc_nxt;
  logic             wrapped_p0;
  logic             wrapped_nxt;
  logic             lerr_p0;
  logic             lerr_nxt;
  logic             wrap_evt;

  // One enabled step, done one bit wider so the carry/borrow is the wrap event.
  // Returns {wrap_event, next_count}.
  function automatic logic [WIDTH:0] advance(input logic [WIDTH-1:0] c, input logic up);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] nxt;
    logic             ev;
    if (up) begin
      s   = {1'b0, c} + (WIDTH+1)'(1);
      ev  = (s >= MOD_W);
      nxt = ev ? ((SATURATE != 0) ? c : '0) : s[WIDTH-1:0];
    end else begin
      s   = {1'b0, c} - (WIDTH+1)'(1);
      ev  = s[WIDTH];
      nxt = ev ? ((SATURATE != 0) ? c : TOP) : s[WIDTH-1:0];
    end
    return {ev, nxt};
  endfunction

  always_comb begin
    term      = bus.up_dn ? TOP : '0;
    count_nxt = count_p0;
    wrap_evt  = 1'b0;
    lerr_nxt  = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.load_val} < MOD_W) begin
        count_nxt = bus.load_val;
      end else begin
        count_nxt = TOP;
        lerr_nxt  = 1'b1;
      end
    end else if (bus.en) begin
      {wrap_evt, count_nxt} = advance(count_p0, bus.up_dn);
    end
    tc_nxt      = (count_nxt == term);
    // A wrap on the same edge as a clear keeps the flag set.
    wrapped_nxt = wrap_evt | (wrapped_p0 & ~bus.clr_flag);
  end

  // p0: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p0   <= '0;
      tc_p0      <= 1'b0;
      wrapped_p0 <= 1'b0;
      lerr_p0    <= 1'b0;
    end else begin
      count_p0   <= count_nxt;
      tc_p0      <= tc_nxt;
      wrapped_p0 <= wrapped_nxt;
      lerr_p0    <= lerr_nxt;
    end
  end

  assign bus.count    = count_p0;
  assign bus.tc       = tc_p0;
  assign bus.co       = tc_p0 & bus.en & ~bus.load;
  assign bus.wrapped  = wrapped_p0;
  assign bus.load_err = lerr_p0;

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: five stages (mod-6, saturating mod-10, mod-16 and a
// mod-10 -> mod-6 cascade) driven in parallel and checked against a reference model.
module tb_mod_n_counter;

  function automatic int mod_of(input int g);
    case (g)
      0, 4:    return 6;
      2:       return 16;
      default: return 10;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_v, en_v, up_v, ld_v, clr_v;
  logic [3:0] lv_v;
  logic [3:0] cnt_o [5];
  logic       tc_o  [5];
  logic       co_o  [5];
  logic       wr_o  [5];
  logic       le_o  [5];

  always #5 clk = ~clk;
  assign rst = rst_v;

  mod_n_counter_if #(.WIDTH(4)) f [5] ();

  for (genvar g = 0; g < 5; g++) begin : g_dut
    mod_n_counter #(.WIDTH(4), .MODULUS(mod_of(g)), .SATURATE(g == 1 ? 1 : 0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (f[g])
    );
    assign f[g].up_dn    = up_v;
    assign f[g].load     = ld_v;
    assign f[g].load_val = lv_v;
    assign f[g].clr_flag = clr_v;
    if (g == 4) begin : g_casc
      assign f[g].en = f[3].co;
    end else begin : g_en
      assign f[g].en = en_v;
    end
    assign cnt_o[g] = f[g].count;
    assign tc_o[g]  = f[g].tc;
    assign co_o[g]  = f[g].co;
    assign wr_o[g]  = f[g].wrapped;
    assign le_o[g]  = f[g].load_err;
  end

  // Reference model: state per stage, advanced with modular arithmetic.
  typedef struct {
    int cnt;
    bit tc;
    bit wr;
    bit le;
  } st_t;

  st_t ms [5];
  int  nchk = 0;
  int  nerr = 0;

  function automatic st_t step(input st_t s, input int m, input bit sat, input bit r,
                               input bit en, input bit up, input bit ld, input int lv,
                               input bit clr);
    st_t n;
    int  term;
    term = up ? m - 1 : 0;
    if (r) begin
      n.cnt = 0; n.tc = 0; n.wr = 0; n.le = 0;
      return n;
    end
    n    = s;
    n.le = 0;
    n.wr = s.wr & ~clr;
    if (ld) begin
      if (lv < m) n.cnt = lv;
      else begin
        n.cnt = m - 1;
        n.le  = 1;
      end
    end else if (en) begin
      if (s.cnt == term) begin
        n.wr = 1;
        if (!sat) n.cnt = (s.cnt + (up ? 1 : m - 1)) % m;
      end else begin
        n.cnt = s.cnt + (up ? 1 : -1);
      end
    end
    n.tc = (n.cnt == term);
    return n;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Inputs are already applied; check carry before the edge, then state after it.
  task automatic cycle();
    bit coe [5];
    #2;
    for (int g = 0; g < 5; g++) begin
      coe[g] = ms[g].tc & ((g == 4) ? coe[3] : en_v) & ~ld_v;
      chk("co", g, 32'(co_o[g]), 32'(coe[g]));
    end
    @(posedge clk);
    for (int g = 0; g < 5; g++)
      ms[g] = step(ms[g], mod_of(g), g == 1, rst_v, (g == 4) ? coe[3] : en_v,
                   up_v, ld_v, int'(lv_v), clr_v);
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("count", g, 32'(cnt_o[g]), 32'(ms[g].cnt));
      chk("tc", g, 32'(tc_o[g]), 32'(ms[g].tc));
      chk("wrapped", g, 32'(wr_o[g]), 32'(ms[g].wr));
      chk("load_err", g, 32'(le_o[g]), 32'(ms[g].le));
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l, input int v, input bit c);
    rst_v = r; en_v = e; up_v = u; ld_v = l; lv_v = 4'(v); clr_v = c;
  endtask

  // Hand-derived vectors for the mod-6 wrapping stage: inputs, then co before
  // the edge and count/tc/wrapped/load_err after it.
  typedef struct {
    bit r, e, u, l;
    int v;
    bit c;
    bit co;
    int cnt;
    bit tc, wr, le;
  } vec_t;

  vec_t tq [$];

  function automatic void add(input bit r, input bit e, input bit u, input bit l, input int v,
                              input bit c, input bit co, input int cnt, input bit tc,
                              input bit wr, input bit le);
    vec_t t;
    t.r = r; t.e = e; t.u = u; t.l = l; t.v = v; t.c = c;
    t.co = co; t.cnt = cnt; t.tc = tc; t.wr = wr; t.le = le;
    tq.push_back(t);
  endfunction

  initial begin
    add(1,1,1,0,0,0, 0,0,0,0,0);
    add(0,1,1,0,0,0, 0,1,0,0,0);
    add(0,1,1,0,0,0, 0,2,0,0,0);
    add(0,1,1,0,0,0, 0,3,0,0,0);
    add(0,1,1,0,0,0, 0,4,0,0,0);
    add(0,1,1,0,0,0, 0,5,1,0,0);
    add(0,1,1,0,0,0, 1,0,0,1,0);
    add(0,1,1,0,0,0, 0,1,0,1,0);
    add(0,1,1,0,0,0, 0,2,0,1,0);
    add(0,1,1,0,0,0, 0,3,0,1,0);
    add(0,1,1,0,0,0, 0,4,0,1,0);
    add(0,1,1,0,0,0, 0,5,1,1,0);
    add(0,1,1,0,0,0, 1,0,0,1,0);
    add(0,1,1,0,0,0, 0,1,0,1,0);
    add(0,1,1,0,0,0, 0,2,0,1,0);
    add(0,1,0,0,0,0, 0,1,0,1,0);
    add(0,1,0,0,0,0, 0,0,1,1,0);
    add(0,1,0,0,0,0, 1,5,0,1,0);
    add(0,0,1,0,0,0, 0,5,1,1,0);
    add(0,0,1,0,0,0, 0,5,1,1,0);
    add(0,0,1,0,0,1, 0,5,1,0,0);
    add(0,1,1,1,3,0, 0,3,0,0,0);
    add(0,0,1,1,9,0, 0,5,1,0,1);
    add(0,0,1,0,0,0, 0,5,1,0,0);
    add(1,1,1,1,3,0, 0,0,0,0,0);
    add(0,1,1,0,0,0, 0,1,0,0,0);
    add(0,0,1,1,5,0, 0,5,1,0,0);
    add(0,1,1,0,0,1, 1,0,0,1,0);
    add(0,0,1,1,6,0, 0,5,1,1,1);
    add(0,0,1,0,0,0, 0,5,1,1,0);
    add(0,1,1,1,15,0, 0,5,1,1,1);

    drive(1, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 5; g++) begin
      ms[g].cnt = 0; ms[g].tc = 0; ms[g].wr = 0; ms[g].le = 0;
    end

    foreach (tq[i]) begin
      drive(tq[i].r, tq[i].e, tq[i].u, tq[i].l, tq[i].v, tq[i].c);
      #2;
      chk("tbl_co", i, 32'(co_o[0]), 32'(tq[i].co));
      cycle();
      chk("tbl_count", i, 32'(cnt_o[0]), 32'(tq[i].cnt));
      chk("tbl_tc", i, 32'(tc_o[0]), 32'(tq[i].tc));
      chk("tbl_wrapped", i, 32'(wr_o[0]), 32'(tq[i].wr));
      chk("tbl_load_err", i, 32'(le_o[0]), 32'(tq[i].le));
    end

    // Cascade, saturation and power-of-two wrap from a common reset.
    drive(1, 1, 1, 0, 0, 0);
    cycle();
    drive(0, 1, 1, 0, 0, 0);
    for (int n = 1; n <= 60; n++) begin
      cycle();
      chk("casc_pair", n, 32'(cnt_o[4]) * 10 + 32'(cnt_o[3]), 32'(n % 60));
      if (n == 12) begin
        chk("sat_count", 1, 32'(cnt_o[1]), 32'd9);
        chk("sat_wrapped", 1, 32'(wr_o[1]), 32'd1);
        #2;
        chk("sat_co", 1, 32'(co_o[1]), 32'd1);
      end
      if (n == 15) begin
        chk("p2_count", 2, 32'(cnt_o[2]), 32'd15);
        chk("p2_tc_up", 2, 32'(tc_o[2]), 32'd1);
      end
      if (n == 16) begin
        chk("p2_wrap", 2, 32'(cnt_o[2]), 32'd0);
        chk("p2_wrapped", 2, 32'(wr_o[2]), 32'd1);
      end
    end
    chk("sat_hold", 1, 32'(cnt_o[1]), 32'd9);

    drive(0, 0, 1, 0, 0, 1);
    cycle();
    chk("sat_clr", 1, 32'(wr_o[1]), 32'd0);

    drive(0, 0, 0, 1, 0, 0);
    cycle();
    chk("p2_ld0", 2, 32'(cnt_o[2]), 32'd0);
    chk("p2_tc_dn", 2, 32'(tc_o[2]), 32'd1);

    drive(0, 1, 0, 0, 0, 0);
    cycle();
    chk("p2_borrow", 2, 32'(cnt_o[2]), 32'd15);
    chk("p2_wr_dn", 2, 32'(wr_o[2]), 32'd1);
    chk("p2_tc_off", 2, 32'(tc_o[2]), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
- Parametrised modulo-N counter: successor to the fixed mod-6 counter in the timer and clock datapaths.
- Adds configurable modulus and width, up/down counting, parallel load, a wrap or saturate mode, a registered terminal-count flag, and a combinational cascade carry.
- Several instances chain into multi-digit counters (for example seconds/minutes) by wiring each co to the next stage's en.

Parameters:
- WIDTH, 4, count register width in bits.
- MODULUS, 6, number of count states (0..MODULUS-1); legal range 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; advances one step per enabled cycle.
- up_dn  input  1  1 = count up, 0 = count down; sampled every cycle.
- load  input  1  parallel-load strobe.
- load_val  input  WIDTH  value to load.
- clr_flag  input  1  clears the sticky wrapped flag.
- count  output  WIDTH  current count (registered).
- tc  output  1  registered terminal-count flag.
- co  output  1  cascade carry/borrow, combinational: tc & en & ~load.
- wrapped  output  1  sticky overflow/underflow flag (registered).
- load_err  output  1  one-cycle pulse: the last load was out of range (registered).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=0, tc=0, wrapped=0, load_err=0. tc is 0 after reset even though 0 is the down terminal; it becomes valid from the first non-reset edge.
- Priority per edge: rst > load > en > hold.
- Terminal value: TERM = MODULUS-1 when up_dn=1; TERM = 0 when up_dn=0.
- load:
  - If load_val < MODULUS: count <= load_val.
  - Otherwise: count <= MODULUS-1, load_err <= 1 for exactly one cycle.
  - load_err is 0 on every other edge.
  - en is ignored during load.
- en=1, load=0, count != TERM: count moves +1 (up) or -1 (down).
- en=1, load=0, count == TERM:
  - SATURATE=0: count wraps to 0 (up) or MODULUS-1 (down); wrapped <= 1.
  - SATURATE=1: count holds; wrapped <= 1.
- en=0, load=0: count holds.
- tc is updated every non-reset edge, regardless of en: tc <= (count_next == TERM evaluated with the up_dn sampled at that edge). So tc=1 exactly while the count register holds the terminal value for the direction in force at the last edge. A direction change with en=0 updates tc on the next edge.
- co cascade rule:
  - co is high in the same cycle the stage wraps (or saturates), so a downstream stage advances on that same edge.
  - No extra latency per stage.
  - co is suppressed while load=1.
- wrapped:
  - Sticky; cleared only by rst, or by clr_flag=1 on an edge.
  - If clr_flag and a wrap event occur on the same edge, set wins (wrapped=1).
- Arithmetic:
  - Increment and decrement are computed at WIDTH+1 bits and compared against the modulus; count never leaves 0..MODULUS-1.
  - MODULUS = 2**WIDTH must wrap naturally with no spurious intermediate value.
- Reset mid-count overrides load and en on the same edge; the cycle after reset behaves as a fresh start.
- No combinational path from any input to count, tc, wrapped or load_err.

Test Plan:
- Up count, MODULUS=6, WIDTH=4, SATURATE=0: rst then en=1, up_dn=1 for 13 cycles -> count 0,1,2,3,4,5,0,1,...; tc=1 and co=1 only while count=5; wrapped=1 after the first 5->0.
- Down count with direction switch, WIDTH=4: from count=2, up_dn=0 with en=1 -> 1,0,5,4; tc=1 while count=0. Hold en=0 at count=5 and set up_dn=1 -> tc rises on the next edge with count still 5.
- Saturate, SATURATE=1, MODULUS=10: en=1, up_dn=1 for 12 cycles -> count stops at 9; co stays 1 while en=1; wrapped=1. clr_flag pulse with en=0 -> wrapped=0.
- Load, MODULUS=6, WIDTH=4:
  - load_val=3 with en=1 -> count=3, co=0 during the load cycle.
  - load_val=9 -> count=5, load_err=1 for one cycle then 0.
  - rst and load asserted together -> count=0.
- Cascade, two stages (MODULUS=10 low, MODULUS=6 high), low.co wired to high.en: 60 enabled cycles from reset -> the pair reads 59 at cycle 59, then 00 at cycle 60; high stage increments on the same edge the low stage wraps 9->0.
- Power-of-two modulus, MODULUS=16, WIDTH=4: count up through 15->0 and down through 0->15 -> tc correct at 15 and at 0, no X, wrapped set.
